// File: rtl/vram_fill_engine.sv
// rtl/vram_fill_engine.sv - VRAM write front end: CPU store passthrough plus hardware rectangle fill
//
// CPU stores to the pixel window or the refresh trigger are forwarded to the
// VRAM write port one cycle later while the engine is idle.  Writes to the
// register window set up a rectangle fill.  The fill streams one pixel word
// per cycle in row-major order and can optionally finish with a refresh write.
module vram_fill_engine #(
  parameter int unsigned SCR_W        = 320,
  parameter int unsigned SCR_H        = 240,
  parameter logic [31:0] VRAM_BASE    = 32'h8000,
  parameter logic [31:0] REFRESH_ADDR = 32'h54000,
  parameter logic [31:0] REG_BASE     = 32'h54010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        vram_we,
  output logic [31:0] vram_addr,
  output logic [31:0] vram_data,
  output logic        busy,
  output logic        done_pulse
);

  localparam logic [31:0] VRAM_END   = VRAM_BASE + 32'(SCR_W * SCR_H * 4);
  localparam logic [31:0] REG_END    = REG_BASE + 32'd24;
  localparam logic [31:0] ROW_STRIDE = 32'(SCR_W * 4);
  localparam logic [31:0] SCR_W32    = 32'(SCR_W);
  localparam logic [16:0] SCR_W17    = 17'(SCR_W);
  localparam logic [16:0] SCR_H17    = 17'(SCR_H);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_REFRESH,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic [15:0] r_w;
  logic [15:0] r_h;
  logic [31:0] r_color;
  logic        r_refresh_on_done;
  logic [16:0] r_ew;
  logic [16:0] r_eh;
  logic [16:0] r_col;
  logic [16:0] r_row;
  logic [31:0] r_row_base;
  logic        r_vram_we;
  logic [31:0] r_vram_addr;
  logic [31:0] r_vram_data;
  logic        r_busy;
  logic        r_done_pulse;

  logic        w_hit_vram;
  logic        w_hit_refresh;
  logic        w_hit_reg;
  logic [2:0]  w_reg_idx;
  logic        w_accept;
  logic        w_start;
  logic [16:0] w_x17;
  logic [16:0] w_y17;
  logic [16:0] w_w17;
  logic [16:0] w_h17;
  logic [16:0] w_room_x;
  logic [16:0] w_room_y;
  logic [16:0] w_ew;
  logic [16:0] w_eh;
  logic        w_empty;
  logic [31:0] w_first_addr;
  logic        w_last_col;
  logic        w_last_row;

  assign w_hit_vram    = (cpu_addr >= VRAM_BASE) && (cpu_addr < VRAM_END);
  assign w_hit_refresh = (cpu_addr == REFRESH_ADDR);
  assign w_hit_reg     = (cpu_addr >= REG_BASE) && (cpu_addr < REG_END);
  assign w_reg_idx     = 3'((cpu_addr - REG_BASE) >> 2);

  // Anything but IDLE (including the DONE cycle) holds off decoded stores so none is lost
  assign cpu_stall = cpu_we && (r_state != S_IDLE) && (w_hit_vram || w_hit_refresh || w_hit_reg);
  assign w_accept  = cpu_we && (r_state == S_IDLE);
  assign w_start   = w_accept && w_hit_reg && (w_reg_idx == 3'd5) && cpu_wdata[0];

  // Clip math is done in 17 bits so SCR_W - X never wraps for legal X
  assign w_x17    = {1'b0, r_x};
  assign w_y17    = {1'b0, r_y};
  assign w_w17    = {1'b0, r_w};
  assign w_h17    = {1'b0, r_h};
  assign w_room_x = SCR_W17 - w_x17;
  assign w_room_y = SCR_H17 - w_y17;
  assign w_ew     = (w_w17 < w_room_x) ? w_w17 : w_room_x;
  assign w_eh     = (w_h17 < w_room_y) ? w_h17 : w_room_y;
  assign w_empty  = (w_x17 >= SCR_W17) || (w_y17 >= SCR_H17) || (r_w == 16'd0) || (r_h == 16'd0);

  // The only multiply is at START; the fill loop itself just adds strides
  assign w_first_addr = VRAM_BASE + (((32'(r_y) * SCR_W32) + 32'(r_x)) << 2);

  assign w_last_col = (r_col == (r_ew - 17'd1));
  assign w_last_row = (r_row == (r_eh - 17'd1));

  // Engine FSM with registered VRAM port, busy and done outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_x               <= '0;
      r_y               <= '0;
      r_w               <= '0;
      r_h               <= '0;
      r_color           <= '0;
      r_refresh_on_done <= 1'b0;
      r_ew              <= '0;
      r_eh              <= '0;
      r_col             <= '0;
      r_row             <= '0;
      r_row_base        <= '0;
      r_vram_we         <= 1'b0;
      r_vram_addr       <= '0;
      r_vram_data       <= '0;
      r_busy            <= 1'b0;
      r_done_pulse      <= 1'b0;
    end else begin
      r_vram_we    <= 1'b0;
      r_done_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && (w_hit_vram || w_hit_refresh)) begin
            r_vram_we   <= 1'b1;
            r_vram_addr <= cpu_addr;
            r_vram_data <= cpu_wdata;
          end
          if (w_accept && w_hit_reg) begin
            case (w_reg_idx)
              3'd0:    r_x <= cpu_wdata[15:0];
              3'd1:    r_y <= cpu_wdata[15:0];
              3'd2:    r_w <= cpu_wdata[15:0];
              3'd3:    r_h <= cpu_wdata[15:0];
              3'd4:    r_color <= cpu_wdata;
              3'd5:    r_refresh_on_done <= cpu_wdata[1];
              default: ;
            endcase
          end
          if (w_start) begin
            r_ew       <= w_ew;
            r_eh       <= w_eh;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= w_first_addr;
            if (!w_empty) begin
              r_state     <= S_FILL;
              r_busy      <= 1'b1;
              r_vram_we   <= 1'b1;
              r_vram_addr <= w_first_addr;
              r_vram_data <= r_color;
            end else if (cpu_wdata[1]) begin
              r_state     <= S_REFRESH;
              r_busy      <= 1'b1;
              r_vram_we   <= 1'b1;
              r_vram_addr <= REFRESH_ADDR;
              r_vram_data <= 32'd1;
            end else begin
              r_state      <= S_DONE;
              r_done_pulse <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (!w_last_col) begin
            r_col       <= r_col + 17'd1;
            r_vram_we   <= 1'b1;
            r_vram_addr <= r_vram_addr + 32'd4;
          end else if (!w_last_row) begin
            r_col       <= '0;
            r_row       <= r_row + 17'd1;
            r_row_base  <= r_row_base + ROW_STRIDE;
            r_vram_we   <= 1'b1;
            r_vram_addr <= r_row_base + ROW_STRIDE;
          end else if (r_refresh_on_done) begin
            r_state     <= S_REFRESH;
            r_vram_we   <= 1'b1;
            r_vram_addr <= REFRESH_ADDR;
            r_vram_data <= 32'd1;
          end else begin
            r_state      <= S_DONE;
            r_busy       <= 1'b0;
            r_done_pulse <= 1'b1;
          end
        end
        S_REFRESH: begin
          r_state      <= S_DONE;
          r_busy       <= 1'b0;
          r_done_pulse <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign vram_we    = r_vram_we;
  assign vram_addr  = r_vram_addr;
  assign vram_data  = r_vram_data;
  assign busy       = r_busy;
  assign done_pulse = r_done_pulse;

endmodule
